// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and FSM state encodings for
// the responder register file and the matching initiator.
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  typedef enum logic [1:0] {
    M_IDLE = 2'b00,
    M_REQ  = 2'b01,
    M_RESP = 2'b10
  } init_state_e;

endpackage

// File: rtl/axi4lite_strb_merge.sv
// Byte-lane merge: each byte takes the new value when its strobe is set and
// keeps the old value otherwise.
module axi4lite_strb_merge #(
  parameter int DATA_WIDTH = 8,
  localparam int SW = DATA_WIDTH / 8
) (
  input  logic [DATA_WIDTH-1:0] old_data,
  input  logic [DATA_WIDTH-1:0] new_data,
  input  logic [SW-1:0]         strb,
  output logic [DATA_WIDTH-1:0] merged
);

  // per-lane select between old and new byte
  always_comb begin
    merged = old_data;
    for (int k = 0; k < SW; k++) begin
      if (strb[k]) begin
        merged[8*k +: 8] = new_data[8*k +: 8];
      end else begin
        merged[8*k +: 8] = old_data[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite responder register file: NREG-1 read/write registers driving the
// fabric plus one read-only status register at the highest address.
module axi4lite_slave_regs
  import axi4lite_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 2,
  parameter int C_S_AXI_DATA_WIDTH = 8,
  localparam int NREG = 32'd1 << C_S_AXI_ADDR_WIDTH,
  localparam int AW   = C_S_AXI_ADDR_WIDTH,
  localparam int DW   = C_S_AXI_DATA_WIDTH,
  localparam int SW   = C_S_AXI_DATA_WIDTH / 8
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_aresetn,
  input  logic [AW-1:0]          s_axi_awaddr,
  input  logic                   s_axi_awvalid,
  output logic                   s_axi_awready,
  input  logic [DW-1:0]          s_axi_wdata,
  input  logic [SW-1:0]          s_axi_wstrb,
  input  logic                   s_axi_wvalid,
  output logic                   s_axi_wready,
  output logic [1:0]             s_axi_bresp,
  output logic                   s_axi_bvalid,
  input  logic                   s_axi_bready,
  input  logic [AW-1:0]          s_axi_araddr,
  input  logic                   s_axi_arvalid,
  output logic                   s_axi_arready,
  output logic [DW-1:0]          s_axi_rdata,
  output logic [1:0]             s_axi_rresp,
  output logic                   s_axi_rvalid,
  input  logic                   s_axi_rready,
  output logic [(NREG-1)*DW-1:0] regs_out,
  output logic [NREG-2:0]        wr_pulse,
  input  logic [DW-1:0]          status_in
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

  wr_state_e       w_state_r, w_state_n;
  rd_state_e       r_state_r, r_state_n;
  logic            aw_held_r, aw_held_n, w_held_r, w_held_n;
  logic [AW-1:0]   aw_addr_r, aw_addr_n;
  logic [DW-1:0]   w_data_r, w_data_n;
  logic [SW-1:0]   w_strb_r, w_strb_n;
  logic            awready_r, wready_r, arready_r;
  logic            bvalid_r, bvalid_n;
  logic [1:0]      bresp_r, bresp_n;
  logic            rvalid_r, rvalid_n;
  logic [DW-1:0]   rdata_r, rdata_n, rd_mux_s;
  logic            aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic [DW-1:0]   regs_r   [NREG-1];
  logic [DW-1:0]   merged_s [NREG-1];
  logic [NREG-2:0] wr_pulse_r;

  // readies are registered, so handshakes never depend combinationally on valid
  assign aw_hs_s = s_axi_awvalid && awready_r;
  assign w_hs_s  = s_axi_wvalid  && wready_r;
  assign ar_hs_s = s_axi_arvalid && arready_r;

  for (genvar g = 0; g < NREG - 1; g++) begin : g_reg
    axi4lite_strb_merge #(.DATA_WIDTH(DW)) u_merge (
      .old_data (regs_r[g]),
      .new_data (w_data_n),
      .strb     (w_strb_n),
      .merged   (merged_s[g])
    );
    assign regs_out[g*DW +: DW] = regs_r[g];
  end

  // write FSM next state: collect AW/W in any order, commit when both present
  always_comb begin
    w_state_n = w_state_r;
    aw_held_n = aw_held_r;
    w_held_n  = w_held_r;
    aw_addr_n = aw_addr_r;
    w_data_n  = w_data_r;
    w_strb_n  = w_strb_r;
    bvalid_n  = bvalid_r;
    bresp_n   = bresp_r;
    commit_s  = 1'b0;
    case (w_state_r)
      W_COLLECT: begin
        if (aw_hs_s) begin
          aw_held_n = 1'b1;
          aw_addr_n = s_axi_awaddr;
        end else begin
          aw_held_n = aw_held_r;
        end
        if (w_hs_s) begin
          w_held_n = 1'b1;
          w_data_n = s_axi_wdata;
          w_strb_n = s_axi_wstrb;
        end else begin
          w_held_n = w_held_r;
        end
        if (aw_held_n && w_held_n) begin
          commit_s  = 1'b1;
          w_state_n = W_RESP;
          bvalid_n  = 1'b1;
          bresp_n   = (aw_addr_n == LAST_ADDR) ? RESP_SLVERR : RESP_OKAY;
        end else begin
          commit_s = 1'b0;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_n  = 1'b0;
          aw_held_n = 1'b0;
          w_held_n  = 1'b0;
          w_state_n = W_COLLECT;
        end else begin
          w_state_n = W_RESP;
        end
      end
      default: begin
        w_state_n = W_COLLECT;
        aw_held_n = 1'b0;
        w_held_n  = 1'b0;
        bvalid_n  = 1'b0;
      end
    endcase
  end

  // read source: status input for the top address, register file otherwise
  always_comb begin
    if (s_axi_araddr == LAST_ADDR) begin
      rd_mux_s = status_in;
    end else begin
      rd_mux_s = regs_r[s_axi_araddr];
    end
  end

  // read FSM next state
  always_comb begin
    r_state_n = r_state_r;
    rvalid_n  = rvalid_r;
    rdata_n   = rdata_r;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_state_n = R_DATA;
          rvalid_n  = 1'b1;
          rdata_n   = rd_mux_s;
        end else begin
          r_state_n = R_IDLE;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          r_state_n = R_IDLE;
          rvalid_n  = 1'b0;
        end else begin
          r_state_n = R_DATA;
        end
      end
      default: begin
        r_state_n = R_IDLE;
        rvalid_n  = 1'b0;
      end
    endcase
  end

  // state, capture and response registers
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      w_state_r <= W_COLLECT;
      r_state_r <= R_IDLE;
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      aw_addr_r <= {AW{1'b0}};
      w_data_r  <= {DW{1'b0}};
      w_strb_r  <= {SW{1'b0}};
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      arready_r <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
      rvalid_r  <= 1'b0;
      rdata_r   <= {DW{1'b0}};
    end else begin
      w_state_r <= w_state_n;
      r_state_r <= r_state_n;
      aw_held_r <= aw_held_n;
      w_held_r  <= w_held_n;
      aw_addr_r <= aw_addr_n;
      w_data_r  <= w_data_n;
      w_strb_r  <= w_strb_n;
      awready_r <= (w_state_n == W_COLLECT) && !aw_held_n;
      wready_r  <= (w_state_n == W_COLLECT) && !w_held_n;
      arready_r <= (r_state_n == R_IDLE);
      bvalid_r  <= bvalid_n;
      bresp_r   <= bresp_n;
      rvalid_r  <= rvalid_n;
      rdata_r   <= rdata_n;
    end
  end

  // register file update and one-cycle write strobes
  always_ff @(posedge s_axi_aclk) begin
    for (int i = 0; i < NREG - 1; i++) begin
      if (!s_axi_aresetn) begin
        regs_r[i]     <= {DW{1'b0}};
        wr_pulse_r[i] <= 1'b0;
      end else begin
        wr_pulse_r[i] <= commit_s && (aw_addr_n == AW'(i));
        if (commit_s && (aw_addr_n == AW'(i))) begin
          regs_r[i] <= merged_s[i];
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_arready = arready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = RESP_OKAY;
  assign wr_pulse      = wr_pulse_r;

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Directed and randomized bench for axi4lite_slave_regs against an array-based
// register model.
module tb_axi4lite_slave_regs;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [1:0]  awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [7:0]  wdata, status_in;
  logic [0:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [7:0]  rdata;
  logic [23:0] regs_out;
  logic [2:0]  wr_pulse;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] mdl [3];
  logic [7:0] old_v;

  always #5 clk = ~clk;

  axi4lite_slave_regs #(.C_S_AXI_ADDR_WIDTH(2), .C_S_AXI_DATA_WIDTH(8)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .regs_out(regs_out), .wr_pulse(wr_pulse), .status_in(status_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] mdl_packed();
    return {mdl[2], mdl[1], mdl[0]};
  endfunction

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W; 0: same cycle
  task automatic axi_write(input logic [1:0] a, input logic [7:0] d, input logic s,
                           input int lead, input int b_delay);
    logic [2:0] exp_pulse;
    logic [1:0] exp_resp;
    int gap;
    if (a == 2'd3) begin
      exp_resp  = 2'b10;
      exp_pulse = 3'b000;
    end else begin
      exp_resp  = 2'b00;
      exp_pulse = 3'b001 << a;
      if (s) mdl[a] = d;
    end
    chk("aw_ready_idle", 32'(awready), 32'd1);
    chk("w_ready_idle", 32'(wready), 32'd1);
    awaddr = a; wdata = d; wstrb = s;
    if (lead == 0) begin
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
    end else begin
      if (lead > 0) wvalid = 1'b1; else awvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk("ready_after_first", 32'({awready, wready}), (lead > 0) ? 32'd2 : 32'd1);
      chk("bvalid_early", 32'(bvalid), 32'd0);
      gap = (lead > 0) ? lead : -lead;
      repeat (gap - 1) tick();
      chk("bvalid_wait", 32'(bvalid), 32'd0);
      if (lead > 0) awvalid = 1'b1; else wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
    end
    chk("bvalid", 32'(bvalid), 32'd1);
    chk("bresp", 32'(bresp), 32'(exp_resp));
    chk("wr_pulse", 32'(wr_pulse), 32'(exp_pulse));
    chk("regs_out", 32'(regs_out), 32'(mdl_packed()));
    chk("ready_in_resp", 32'({awready, wready}), 32'd0);
    for (int i = 0; i < b_delay; i++) begin
      tick();
      chk("bvalid_stall", 32'(bvalid), 32'd1);
      chk("bresp_stall", 32'(bresp), 32'(exp_resp));
      chk("ready_stall", 32'({awready, wready}), 32'd0);
      chk("pulse_stall", 32'(wr_pulse), 32'd0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_done", 32'(bvalid), 32'd0);
    chk("ready_done", 32'({awready, wready}), 32'd3);
    chk("pulse_done", 32'(wr_pulse), 32'd0);
  endtask

  task automatic axi_read(input logic [1:0] a, input logic [7:0] st, input int r_delay);
    logic [7:0] exp;
    exp = (a == 2'd3) ? st : mdl[a];
    chk("ar_ready_idle", 32'(arready), 32'd1);
    araddr = a; status_in = st; arvalid = 1'b1;
    tick();
    arvalid = 1'b0; status_in = ~st;
    chk("rvalid", 32'(rvalid), 32'd1);
    chk("rdata", 32'(rdata), 32'(exp));
    chk("rresp", 32'(rresp), 32'd0);
    chk("ar_ready_busy", 32'(arready), 32'd0);
    for (int i = 0; i < r_delay; i++) begin
      tick();
      chk("rvalid_stall", 32'(rvalid), 32'd1);
      chk("rdata_stall", 32'(rdata), 32'(exp));
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rvalid_done", 32'(rvalid), 32'd0);
    chk("ar_ready_done", 32'(arready), 32'd1);
  endtask

  initial begin
    aresetn = 1'b0; awaddr = 2'd0; araddr = 2'd0; wdata = 8'd0; wstrb = 1'b0;
    awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    status_in = 8'h00;
    for (int i = 0; i < 3; i++) mdl[i] = 8'h00;

    // reset with awvalid held high
    repeat (3) tick();
    chk("rst_ready", 32'({awready, wready, arready}), 32'd0);
    chk("rst_valid", 32'({bvalid, rvalid}), 32'd0);
    chk("rst_resp", 32'({bresp, rresp}), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_regs", 32'(regs_out), 32'd0);
    chk("rst_pulse", 32'(wr_pulse), 32'd0);
    awvalid = 1'b0;
    aresetn = 1'b1;
    tick();
    chk("rel_ready", 32'({awready, wready, arready}), 32'd7);

    axi_write(2'd1, 8'hA5, 1'b1, 0, 0);
    axi_write(2'd0, 8'h3C, 1'b1, 3, 0);
    axi_write(2'd3, 8'hFF, 1'b1, 0, 0);
    axi_read(2'd3, 8'h5A, 0);
    axi_write(2'd2, 8'h11, 1'b1, -1, 4);
    axi_write(2'd1, 8'h77, 1'b0, 0, 1);

    // read and write to the same address committing on the same edge
    old_v = mdl[2];
    araddr = 2'd2; arvalid = 1'b1;
    awaddr = 2'd2; wdata = 8'hC3; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    mdl[2] = 8'hC3;
    chk("same_rvalid", 32'(rvalid), 32'd1);
    chk("same_rdata_old", 32'(rdata), 32'(old_v));
    chk("same_bvalid", 32'(bvalid), 32'd1);
    chk("same_regs", 32'(regs_out), 32'(mdl_packed()));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("same_bdone", 32'(bvalid), 32'd0);
    repeat (2) begin
      tick();
      chk("same_rdata_hold", 32'(rdata), 32'(old_v));
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("same_rdone", 32'(rvalid), 32'd0);
    axi_read(2'd2, 8'h00, 0);

    // reset between AW and W discards the held address
    awaddr = 2'd1; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("mid_aw_held", 32'({awready, wready}), 32'd1);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) mdl[i] = 8'h00;
    tick();
    chk("mid_regs", 32'(regs_out), 32'd0);
    chk("mid_ready", 32'({awready, wready}), 32'd3);
    wdata = 8'h99; wstrb = 1'b1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("mid_no_b", 32'(bvalid), 32'd0);
    chk("mid_w_held", 32'({awready, wready}), 32'd2);
    awaddr = 2'd1; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    mdl[1] = 8'h99;
    chk("mid_b", 32'(bvalid), 32'd1);
    chk("mid_regs2", 32'(regs_out), 32'(mdl_packed()));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("mid_bdone", 32'(bvalid), 32'd0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        axi_write(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom),
                  int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
      end else begin
        axi_read(2'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 3)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi4lite_slave_regs.md
Name: axi4lite_slave_regs

Overview:
AXI4-Lite responder (slave) register file. It terminates transactions from the team's AXI4-Lite initiator.
- 2^C_S_AXI_ADDR_WIDTH registers, each C_S_AXI_DATA_WIDTH bits wide.
- All registers except the highest address are read/write. Their contents drive fabric logic.
- The highest address is a read-only status register, sampled from status_in.
- Sits between the initiator and the user datapath of the tile.

Parameters:
C_S_AXI_ADDR_WIDTH, 2, address bits; register count NREG = 2^C_S_AXI_ADDR_WIDTH.
C_S_AXI_DATA_WIDTH, 8, data bits per register; multiple of 8.

Ports:
s_axi_aclk  in  1  clock; all logic on the rising edge.
s_axi_aresetn  in  1  reset, synchronous, active-low.
s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
s_axi_awvalid  in  1  write address valid.
s_axi_awready  out  1  write address ready.
s_axi_wdata  in  C_S_AXI_DATA_WIDTH  write data.
s_axi_wstrb  in  C_S_AXI_DATA_WIDTH/8  byte strobes.
s_axi_wvalid  in  1  write data valid.
s_axi_wready  out  1  write data ready.
s_axi_bresp  out  2  write response.
s_axi_bvalid  out  1  write response valid.
s_axi_bready  in  1  write response ready.
s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
s_axi_arvalid  in  1  read address valid.
s_axi_arready  out  1  read address ready.
s_axi_rdata  out  C_S_AXI_DATA_WIDTH  read data.
s_axi_rresp  out  2  read response.
s_axi_rvalid  out  1  read data valid.
s_axi_rready  in  1  read data ready.
regs_out  out  (NREG-1)*C_S_AXI_DATA_WIDTH  R/W register contents; reg i is at bits [i*DW +: DW].
wr_pulse  out  NREG-1  one-cycle strobe when R/W reg i is written.
status_in  in  C_S_AXI_DATA_WIDTH  source of the read-only register NREG-1.

Behaviour:
- Reset: one clock, one synchronous reset (s_axi_aresetn low, sampled on the rising edge). While reset is held:
  - all registers = 0, regs_out = 0, wr_pulse = 0;
  - bvalid = rvalid = 0, bresp = rresp = 2'b00, rdata = 0;
  - awready = wready = arready = 0;
  - both FSMs go to their idle state and all held AW/W captures are discarded.
- A reset asserted mid-transaction drops the transaction silently. No response is issued.
- Ready signals are decoded from registered state only. There is no combinational path from any valid input to any ready output.
- Write FSM, W_COLLECT:
  - awready = !aw_held; wready = !w_held.
  - AW and W are accepted independently in either order or in the same cycle. The held copy stores addr, data and strb.
  - On the edge where both are present (held or handshaking that cycle), the write commits and the FSM goes to W_RESP.
  - Commit to a R/W register: byte k is updated iff wstrb[k]; wr_pulse[addr] = 1 for exactly the next cycle; bresp = OKAY (2'b00).
  - All-zero strobe: no byte changes, wr_pulse still fires, bresp = OKAY.
  - Commit to address NREG-1: no state change, no pulse, bresp = SLVERR (2'b10).
- Write FSM, W_RESP:
  - bvalid = 1; awready = wready = 0.
  - bvalid and bresp stay stable until bready is sampled high.
  - On that edge: bvalid <= 0, held flags cleared, back to W_COLLECT.
- Write latency: bvalid rises one cycle after the later of the AW/W handshakes. Register contents are visible on regs_out in that same cycle.
- Read FSM, R_IDLE:
  - arready = 1.
  - On an AR handshake: rdata <= selected register (status_in sampled on that edge for addr NREG-1); rresp = OKAY; rvalid <= 1; go to R_DATA.
- Read FSM, R_DATA:
  - arready = 0.
  - rvalid and rdata are held until rready is sampled high, then back to R_IDLE.
  - Minimum AR-to-AR spacing is 2 cycles.
- Read and write channels are fully independent. A read and a write committing on the same edge to the same address return the pre-write value.
- A one-cycle awvalid/wvalid pulse from the initiator is always captured when the corresponding ready is high. An initiator that drops valid without a handshake is out of protocol, and the block's behaviour in that case is unspecified.

Decomposition:
- Shared package axi4lite_pkg holds:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  - write FSM state encodings W_COLLECT and W_RESP;
  - read FSM state encodings R_IDLE and R_DATA.
- The initiator's state encodings also belong in axi4lite_pkg.
- One sub-module, axi4lite_strb_merge: purely combinational byte-lane merge of old data, new data and strobe. Instantiated once per R/W register.

Test Plan:
- Reset with awvalid held high -> all outputs 0; after release, awready = wready = arready = 1 on the first cycle.
- AW addr 1 and W 0xA5, strb 1 in the same cycle, bready = 1 -> next cycle bvalid = 1, bresp = 00, regs_out[15:8] = 0xA5, wr_pulse = 3'b010 for one cycle.
- W 0x3C first, AW addr 0 three cycles later -> wready drops after W; bvalid one cycle after AW; reg0 = 0x3C.
- Write 0xFF to addr 3 -> bresp = 2'b10, status unchanged. Read addr 3 with status_in = 0x5A -> rdata = 0x5A, rresp = 00.
- bready held low for 4 cycles after a write -> bvalid stays stable; awready and wready stay 0; a second AW is not accepted until after the B handshake.
- Read addr 2 with rready delayed 3 cycles while a write to addr 2 commits -> rdata holds the old value; a later read returns the new value.
